// File: rtl/txr_packet_arbiter.sv
// Round-robin arbiter merging several TX engine packet streams onto the single TXR
// packet port; grant is held for a whole packet and the merged beat is registered once.

module txr_packet_arbiter_lane (
  input  logic valid_i,
  input  logic start_i,
  input  logic grant_i,
  input  logic load_i,
  input  logic locked_i,
  output logic ready_o,
  output logic acc_o,
  output logic err_o
);
  assign ready_o = grant_i & load_i;
  assign acc_o   = ready_o & valid_i;
  // Idle: a beat lacking START can never win. Locked: START showing up mid-packet.
  assign err_o   = locked_i ? (acc_o & start_i) : (valid_i & ~start_i);
endmodule

module txr_packet_arbiter #(
  parameter  int C_PCI_DATA_WIDTH = 128,
  parameter  int C_NUM_REQUESTERS = 2,
  localparam int OW = (C_PCI_DATA_WIDTH / 32 > 1) ? $clog2(C_PCI_DATA_WIDTH / 32) : 1
) (
  input  logic                                         CLK,
  input  logic                                         RST_IN,
  input  logic [C_NUM_REQUESTERS*C_PCI_DATA_WIDTH-1:0] REQ_PKT,
  input  logic [C_NUM_REQUESTERS-1:0]                  REQ_PKT_VALID,
  input  logic [C_NUM_REQUESTERS-1:0]                  REQ_PKT_START_FLAG,
  input  logic [C_NUM_REQUESTERS*OW-1:0]               REQ_PKT_START_OFFSET,
  input  logic [C_NUM_REQUESTERS-1:0]                  REQ_PKT_END_FLAG,
  input  logic [C_NUM_REQUESTERS*OW-1:0]               REQ_PKT_END_OFFSET,
  output logic [C_NUM_REQUESTERS-1:0]                  REQ_PKT_READY,
  output logic [C_PCI_DATA_WIDTH-1:0]                  TXR_PKT,
  output logic                                         TXR_PKT_VALID,
  output logic                                         TXR_PKT_START_FLAG,
  output logic [OW-1:0]                                TXR_PKT_START_OFFSET,
  output logic                                         TXR_PKT_END_FLAG,
  output logic [OW-1:0]                                TXR_PKT_END_OFFSET,
  input  logic                                         TXR_PKT_READY,
  output logic [C_NUM_REQUESTERS-1:0]                  GRANT,
  output logic                                         ERR_PROTOCOL
);
  localparam int N  = C_NUM_REQUESTERS;
  localparam int W  = C_PCI_DATA_WIDTH;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_LOCKED = 1'b1;

  logic [N-1:0][W-1:0]  pkt;
  logic [N-1:0][OW-1:0] soff, eoff;
  assign pkt  = REQ_PKT;
  assign soff = REQ_PKT_START_OFFSET;
  assign eoff = REQ_PKT_END_OFFSET;

  logic [0:0]    state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] owner_q, owner_d;
  logic          err_q, err_d;
  logic          out_vld_q, out_vld_d;
  logic [W-1:0]  out_pkt_q, out_pkt_d;
  logic          out_sf_q, out_sf_d, out_ef_q, out_ef_d;
  logic [OW-1:0] out_so_q, out_so_d, out_eo_q, out_eo_d;

  logic [N-1:0]  cand, grant, ready, acc, lane_err;
  logic          win_found, sel_any, load, locked, acc_any;
  logic [IW-1:0] win_idx, sel_idx;

  assign cand   = REQ_PKT_VALID & REQ_PKT_START_FLAG;
  assign locked = (state_q == S_LOCKED);

  // First START candidate at or after the round-robin pointer, wrapping.
  always_comb begin
    logic [IW-1:0] j;
    j         = '0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < N; k++) begin
      j = IW'((int'(ptr_q) + k) % N);
      if (!win_found && cand[j]) begin
        win_found = 1'b1;
        win_idx   = j;
      end
    end
  end

  assign load    = (~out_vld_q | TXR_PKT_READY) & ~RST_IN;
  assign sel_idx = locked ? owner_q : win_idx;
  assign sel_any = (locked | win_found) & ~RST_IN;
  assign grant   = sel_any ? ({{(N-1){1'b0}}, 1'b1} << sel_idx) : '0;

  for (genvar i = 0; i < N; i++) begin : g_lane
    txr_packet_arbiter_lane u_lane (
      .valid_i  (REQ_PKT_VALID[i]),
      .start_i  (REQ_PKT_START_FLAG[i]),
      .grant_i  (grant[i]),
      .load_i   (load),
      .locked_i (locked),
      .ready_o  (ready[i]),
      .acc_o    (acc[i]),
      .err_o    (lane_err[i])
    );
  end

  assign acc_any = |acc;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    err_d     = err_q | ((|lane_err) & ~RST_IN);
    out_vld_d = out_vld_q;
    out_pkt_d = out_pkt_q;
    out_sf_d  = out_sf_q;
    out_ef_d  = out_ef_q;
    out_so_d  = out_so_q;
    out_eo_d  = out_eo_q;
    if (acc_any) begin
      out_vld_d = 1'b1;
      out_pkt_d = pkt[sel_idx];
      out_sf_d  = REQ_PKT_START_FLAG[sel_idx];
      out_ef_d  = REQ_PKT_END_FLAG[sel_idx];
      out_so_d  = soff[sel_idx];
      out_eo_d  = eoff[sel_idx];
      if (!locked) begin
        ptr_d   = (win_idx == IW'(N - 1)) ? '0 : win_idx + 1'b1;
        owner_d = win_idx;
        if (!REQ_PKT_END_FLAG[sel_idx]) state_d = S_LOCKED;
      end else if (REQ_PKT_END_FLAG[sel_idx]) begin
        state_d = S_IDLE;
      end
    end else if (TXR_PKT_READY) begin
      out_vld_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST_IN) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      owner_q   <= '0;
      err_q     <= 1'b0;
      out_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      err_q     <= err_d;
      out_vld_q <= out_vld_d;
    end
  end

  // Payload needs no reset: it is only observed while out_vld_q is set.
  always_ff @(posedge CLK) begin
    out_pkt_q <= out_pkt_d;
    out_sf_q  <= out_sf_d;
    out_ef_q  <= out_ef_d;
    out_so_q  <= out_so_d;
    out_eo_q  <= out_eo_d;
  end

  assign REQ_PKT_READY        = ready;
  assign GRANT                = grant;
  assign ERR_PROTOCOL         = err_q;
  assign TXR_PKT_VALID        = out_vld_q;
  assign TXR_PKT              = out_pkt_q;
  assign TXR_PKT_START_FLAG   = out_sf_q;
  assign TXR_PKT_END_FLAG     = out_ef_q;
  assign TXR_PKT_START_OFFSET = out_so_q;
  assign TXR_PKT_END_OFFSET   = out_eo_q;
endmodule

// File: tb/tb_txr_packet_arbiter.sv
// Bench for txr_packet_arbiter: per-requester beat queues, a packet-level reference
// model checked every cycle, and directed scenarios with literal expectations.

module tb_txr_packet_arbiter;
  localparam int W  = 128;
  localparam int N  = 2;
  localparam int OW = 2;

  typedef struct packed {
    logic [W-1:0]  d;
    logic          st;
    logic          en;
    logic [OW-1:0] so;
    logic [OW-1:0] eo;
  } beat_t;

  logic              CLK = 1'b0;
  logic              RST_IN;
  logic [N*W-1:0]    REQ_PKT;
  logic [N-1:0]      REQ_PKT_VALID, REQ_PKT_START_FLAG, REQ_PKT_END_FLAG, REQ_PKT_READY;
  logic [N*OW-1:0]   REQ_PKT_START_OFFSET, REQ_PKT_END_OFFSET;
  logic [W-1:0]      TXR_PKT;
  logic              TXR_PKT_VALID, TXR_PKT_START_FLAG, TXR_PKT_END_FLAG, TXR_PKT_READY;
  logic [OW-1:0]     TXR_PKT_START_OFFSET, TXR_PKT_END_OFFSET;
  logic [N-1:0]      GRANT;
  logic              ERR_PROTOCOL;

  txr_packet_arbiter #(.C_PCI_DATA_WIDTH(W), .C_NUM_REQUESTERS(N)) dut (
    .CLK(CLK), .RST_IN(RST_IN),
    .REQ_PKT(REQ_PKT), .REQ_PKT_VALID(REQ_PKT_VALID),
    .REQ_PKT_START_FLAG(REQ_PKT_START_FLAG), .REQ_PKT_START_OFFSET(REQ_PKT_START_OFFSET),
    .REQ_PKT_END_FLAG(REQ_PKT_END_FLAG), .REQ_PKT_END_OFFSET(REQ_PKT_END_OFFSET),
    .REQ_PKT_READY(REQ_PKT_READY),
    .TXR_PKT(TXR_PKT), .TXR_PKT_VALID(TXR_PKT_VALID),
    .TXR_PKT_START_FLAG(TXR_PKT_START_FLAG), .TXR_PKT_END_FLAG(TXR_PKT_END_FLAG),
    .TXR_PKT_START_OFFSET(TXR_PKT_START_OFFSET), .TXR_PKT_END_OFFSET(TXR_PKT_END_OFFSET),
    .TXR_PKT_READY(TXR_PKT_READY), .GRANT(GRANT), .ERR_PROTOCOL(ERR_PROTOCOL)
  );

  always #5 CLK = ~CLK;

  int          n_chk = 0, n_err = 0;
  bit          chk_en = 1'b0;
  beat_t       q0[$], q1[$];
  logic [31:0] xfer_log[$];

  // Reference state: packet owner (-1 none), round-robin pointer, output register.
  int    m_owner = -1, m_ptr = 0;
  bit    m_ov = 1'b0, m_err = 1'b0;
  beat_t m_out;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit has(input int r);
    return (r == 0) ? (q0.size() != 0) : (q1.size() != 0);
  endfunction

  function automatic beat_t front(input int r);
    return (r == 0) ? q0[0] : q1[0];
  endfunction

  task automatic drive();
    for (int r = 0; r < N; r++) begin
      beat_t b;
      b = '0;
      if (has(r)) b = front(r);
      REQ_PKT_VALID[r]              = has(r);
      REQ_PKT[r*W +: W]             = b.d;
      REQ_PKT_START_FLAG[r]         = b.st;
      REQ_PKT_END_FLAG[r]           = b.en;
      REQ_PKT_START_OFFSET[r*OW +: OW] = b.so;
      REQ_PKT_END_OFFSET[r*OW +: OW]   = b.eo;
    end
  endtask

  // Beat tag in the low dword: {requester, packet id, beat index}.
  task automatic push_pkt(input int r, input int id, input int nb, input bit start_ok = 1'b1);
    for (int i = 0; i < nb; i++) begin
      beat_t b;
      b.d  = {$urandom, $urandom, $urandom, 8'(r), 8'(id), 16'(i)};
      b.st = (i == 0) && start_ok;
      b.en = (i == nb - 1);
      b.so = OW'($urandom);
      b.eo = OW'($urandom);
      if (r == 0) q0.push_back(b); else q1.push_back(b);
    end
    drive();
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1 drive();
    #1;
  endtask

  task automatic do_reset();
    RST_IN = 1'b1;
    q0.delete();
    q1.delete();
    drive();
    cyc();
    cyc();
    RST_IN = 1'b0;
    chk_en = 1'b1;
  endtask

  task automatic chk_log(input string nm, input int n, input logic [31:0] e [0:7]);
    chk({nm, "_len"}, 128'(xfer_log.size()), 128'(n));
    for (int i = 0; i < n && i < xfer_log.size(); i++) chk(nm, 128'(xfer_log[i]), 128'(e[i]));
  endtask

  // Who may move a beat this cycle: the packet owner, else the first START
  // requester found walking round from the pointer; it moves if the output frees.
  function automatic void predict(output logic [N-1:0] rdy, output logic [N-1:0] gnt,
                                  output int w);
    rdy = '0;
    gnt = '0;
    w   = -1;
    if (RST_IN) return;
    if (m_owner >= 0) w = m_owner;
    else
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (w < 0 && REQ_PKT_VALID[j] && REQ_PKT_START_FLAG[j]) w = j;
      end
    if (w >= 0) begin
      gnt[w] = 1'b1;
      rdy[w] = !m_ov || TXR_PKT_READY;
    end
  endfunction

  always @(posedge CLK) begin : model
    logic [N-1:0] rdy, gnt;
    int w;
    beat_t b;
    predict(rdy, gnt, w);
    if (RST_IN) begin
      m_owner = -1; m_ptr = 0; m_ov = 1'b0; m_err = 1'b0;
    end else begin
      if (m_owner < 0)
        for (int j = 0; j < N; j++)
          if (REQ_PKT_VALID[j] && !REQ_PKT_START_FLAG[j]) m_err = 1'b1;
      if (w >= 0 && rdy[w] && REQ_PKT_VALID[w]) begin
        b = front(w);
        if (w == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        if (m_owner >= 0 && b.st) m_err = 1'b1;
        if (m_owner < 0) m_ptr = (w + 1) % N;
        m_owner = b.en ? -1 : w;
        m_out   = b;
        m_ov    = 1'b1;
      end else if (TXR_PKT_READY) begin
        m_ov = 1'b0;
      end
    end
  end

  always @(negedge CLK) begin : compare
    logic [N-1:0] rdy, gnt;
    int w;
    if (chk_en) begin
      predict(rdy, gnt, w);
      chk("ready", 128'(REQ_PKT_READY), 128'(rdy));
      chk("grant", 128'(GRANT), 128'(gnt));
      chk("out_valid", 128'(TXR_PKT_VALID), 128'(m_ov));
      chk("err", 128'(ERR_PROTOCOL), 128'(m_err));
      if (m_ov) begin
        chk("out_data", TXR_PKT, m_out.d);
        chk("out_flags", 128'({TXR_PKT_START_FLAG, TXR_PKT_END_FLAG}), 128'({m_out.st, m_out.en}));
        chk("out_offs", 128'({TXR_PKT_START_OFFSET, TXR_PKT_END_OFFSET}), 128'({m_out.so, m_out.eo}));
      end
      if (TXR_PKT_VALID === 1'b1 && TXR_PKT_READY === 1'b1) xfer_log.push_back(TXR_PKT[31:0]);
    end
  end

  initial begin
    logic [31:0] e [0:7];
    int cnt0, alt_bad;
    RST_IN = 1'b1;
    TXR_PKT_READY = 1'b1;
    drive();

    // Reset state
    do_reset();
    chk("rst_valid", 128'(TXR_PKT_VALID), 128'd0);
    chk("rst_ready", 128'(REQ_PKT_READY), 128'd0);
    chk("rst_grant", 128'(GRANT), 128'd0);
    chk("rst_err", 128'(ERR_PROTOCOL), 128'd0);

    // Single requester, 3-beat packet
    xfer_log.delete();
    push_pkt(0, 1, 3);
    #1;
    chk("t1_grant0", 128'(GRANT), 128'b01);
    chk("t1_ready0", 128'(REQ_PKT_READY), 128'b01);
    cyc();
    chk("t1_b0", 128'({TXR_PKT_VALID, TXR_PKT_START_FLAG, TXR_PKT_END_FLAG, TXR_PKT[31:0]}),
        128'({3'b110, 32'h0001_0000}));
    chk("t1_grant1", 128'(GRANT), 128'b01);
    cyc();
    chk("t1_b1", 128'({TXR_PKT_VALID, TXR_PKT_START_FLAG, TXR_PKT_END_FLAG, TXR_PKT[31:0]}),
        128'({3'b100, 32'h0001_0001}));
    cyc();
    chk("t1_b2", 128'({TXR_PKT_VALID, TXR_PKT_START_FLAG, TXR_PKT_END_FLAG, TXR_PKT[31:0]}),
        128'({3'b101, 32'h0001_0002}));
    chk("t1_grant_end", 128'(GRANT), 128'b00);
    cyc();
    chk("t1_drain", 128'(TXR_PKT_VALID), 128'd0);

    // Contention, pointer at 0
    do_reset();
    xfer_log.delete();
    push_pkt(0, 2, 2);
    push_pkt(1, 2, 2);
    e = '{32'h0002_0000, 32'h0002_0001, 32'h0102_0000, 32'h0102_0001, 0, 0, 0, 0};
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("t2_seq", 128'({TXR_PKT_VALID, TXR_PKT[31:0]}), 128'({1'b1, e[i]}));
    end
    push_pkt(0, 3, 1);
    push_pkt(1, 3, 1);
    #1;
    chk("t2_ptr_back_to_0", 128'(GRANT), 128'b01);
    cyc();
    chk("t2_next_rr", 128'(GRANT), 128'b10);
    cyc();
    cyc();

    // Fairness: 50 single-beat packets each, streamed back to back
    do_reset();
    xfer_log.delete();
    for (int i = 0; i < 50; i++) begin
      push_pkt(0, i, 1);
      push_pkt(1, i, 1);
    end
    repeat (101) cyc();
    chk("t3_no_bubble", 128'(xfer_log.size()), 128'd100);
    repeat (2) cyc();
    cnt0 = 0;
    alt_bad = 0;
    foreach (xfer_log[k]) begin
      if (xfer_log[k][31:24] == 8'd0) cnt0++;
      if (int'(xfer_log[k][31:24]) != k % 2) alt_bad++;
    end
    chk("t3_total", 128'(xfer_log.size()), 128'd100);
    chk("t3_req0_share", 128'(cnt0), 128'd50);
    chk("t3_alternate", 128'(alt_bad), 128'd0);

    // Backpressure mid-packet
    do_reset();
    xfer_log.delete();
    push_pkt(0, 4, 4);
    push_pkt(1, 4, 1);
    cyc();
    cyc();
    TXR_PKT_READY = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("t4_hold", 128'({TXR_PKT_VALID, TXR_PKT[31:0]}), 128'({1'b1, 32'h0004_0001}));
      chk("t4_ready", 128'(REQ_PKT_READY), 128'b00);
      chk("t4_owner", 128'(GRANT), 128'b01);
    end
    TXR_PKT_READY = 1'b1;
    repeat (4) cyc();
    e = '{32'h0004_0000, 32'h0004_0001, 32'h0004_0002, 32'h0004_0003, 32'h0104_0000, 0, 0, 0};
    chk_log("t4_log", 5, e);

    // Protocol error: req1 presents a beat without START while idle
    do_reset();
    xfer_log.delete();
    push_pkt(1, 5, 1, 1'b0);
    #1;
    chk("t5_err_before", 128'(ERR_PROTOCOL), 128'd0);
    chk("t5_no_grant", 128'(GRANT), 128'b00);
    cyc();
    chk("t5_err_set", 128'(ERR_PROTOCOL), 128'd1);
    push_pkt(0, 5, 1);
    #1;
    chk("t5_req0_wins", 128'(GRANT), 128'b01);
    repeat (3) cyc();
    chk("t5_err_sticky", 128'(ERR_PROTOCOL), 128'd1);
    chk("t5_req1_stalled", 128'(GRANT), 128'b00);
    e = '{32'h0005_0000, 0, 0, 0, 0, 0, 0, 0};
    chk_log("t5_log", 1, e);
    do_reset();
    chk("t5_err_cleared", 128'(ERR_PROTOCOL), 128'd0);

    // Reset in the middle of a 4-beat packet
    xfer_log.delete();
    push_pkt(0, 6, 4);
    cyc();
    cyc();
    RST_IN = 1'b1;
    q0.delete();
    q1.delete();
    drive();
    cyc();
    chk("t6_valid", 128'(TXR_PKT_VALID), 128'd0);
    chk("t6_grant", 128'(GRANT), 128'b00);
    chk("t6_ready", 128'(REQ_PKT_READY), 128'b00);
    RST_IN = 1'b0;
    push_pkt(1, 6, 2);
    #1;
    chk("t6_new_grant", 128'({GRANT, REQ_PKT_READY}), 128'b1010);
    cyc();
    chk("t6_nb0", 128'({TXR_PKT_VALID, TXR_PKT_START_FLAG, TXR_PKT[31:0]}), 128'({2'b11, 32'h0106_0000}));
    cyc();
    chk("t6_nb1", 128'({TXR_PKT_VALID, TXR_PKT_END_FLAG, TXR_PKT[31:0]}), 128'({2'b11, 32'h0106_0001}));
    cyc();
    e = '{32'h0006_0000, 32'h0006_0001, 32'h0106_0000, 32'h0106_0001, 0, 0, 0, 0};
    chk_log("t6_log", 4, e);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
